uart_frame_packer: RTL and testbench

Framing stage directly upstream of the UART transmitter. Buffers audio samples from the I2S capture path in a small FIFO, groups every N_CH samples into a framed packet (header, sequence number, big-endian payload, checksum), and hands the packet byte by byte to the UART transmitter through its one-byte enable/done handshake.

---
 rtl/uart_frame_packer.sv | 178 +++++++++++++++++
 tb/tb_uart_frame_packer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_packer.sv
// Sample FIFO plus byte-serial framer feeding a UART transmitter over an en/done handshake.
// Frame: HDR0, HDR1, SEQ, N_CH big-endian samples, CSUM = (SEQ + payload) mod 256.
module uart_frame_packer #(
   parameter int unsigned SAMPLE_W = 16,
   parameter int unsigned N_CH     = 4,
   parameter int unsigned FIFO_AW  = 4,
   parameter logic [7:0]  HDR0     = 8'hA5,
   parameter logic [7:0]  HDR1     = 8'h5A
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample_data,
   input  logic                clear_ovf,
   output logic                uart_tx_en,
   output logic [7:0]          uart_tx_data,
   input  logic                uart_tx_done,
   output logic                busy,
   output logic                overflow,
   output logic [FIFO_AW:0]    fifo_level
);

   localparam int unsigned BYTES = SAMPLE_W / 8;
   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int unsigned CW    = FIFO_AW + 1;
   localparam logic [BW-1:0]      LAST_BYTE = BW'(BYTES - 1);
   localparam logic [FIFO_AW-1:0] LAST_SAMP = FIFO_AW'(N_CH - 1);

   typedef enum logic [2:0] {StIdle, StHdr0, StHdr1, StSeq, StPay, StCsum} state_e;

   logic [SAMPLE_W-1:0] mem [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]       count_q;
   logic                ovf_q;
   logic                full, push, pop, drop;
   logic [SAMPLE_W-1:0] head;

   state_e              state_q, state_d;
   logic                launch_q, launch_d;
   logic [BW-1:0]       byte_idx_q, byte_idx_d;
   logic [FIFO_AW-1:0]  samp_idx_q, samp_idx_d;
   logic [7:0]          seq_q, seq_d;
   logic [7:0]          csum_q, csum_d;
   logic [7:0]          data_q, data_d;
   logic [7:0]          pay_byte, cur_byte;

   assign full = (count_q == CW'(DEPTH));
   // A full FIFO still accepts a sample when the head leaves in the same cycle.
   assign push = sample_valid && (!full || pop);
   assign drop = sample_valid && full && !pop;
   assign head = mem[rd_ptr_q];

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (drop)           ovf_q <= 1'b1;
         else if (clear_ovf) ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (push) mem[wr_ptr_q] <= sample_data;
   end

   always_comb begin
      pay_byte = 8'h00;
      for (int b = 0; b < BYTES; b++) begin
         if (byte_idx_q == BW'(b)) pay_byte = head[SAMPLE_W-1-8*b -: 8];
      end
      case (state_q)
         StHdr0:  cur_byte = HDR0;
         StHdr1:  cur_byte = HDR1;
         StSeq:   cur_byte = seq_q;
         StPay:   cur_byte = pay_byte;
         StCsum:  cur_byte = csum_q;
         default: cur_byte = 8'h00;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= StIdle;
         launch_q   <= 1'b0;
         byte_idx_q <= '0;
         samp_idx_q <= '0;
         seq_q      <= 8'h00;
         csum_q     <= 8'h00;
         data_q     <= 8'h00;
      end else begin
         state_q    <= state_d;
         launch_q   <= launch_d;
         byte_idx_q <= byte_idx_d;
         samp_idx_q <= samp_idx_d;
         seq_q      <= seq_d;
         csum_q     <= csum_d;
         data_q     <= data_d;
      end
   end

   // launch_q selects the one-cycle LAUNCH phase of a byte state; otherwise WAIT.
   always_comb begin
      state_d    = state_q;
      launch_d   = launch_q;
      byte_idx_d = byte_idx_q;
      samp_idx_d = samp_idx_q;
      seq_d      = seq_q;
      csum_d     = csum_q;
      data_d     = data_q;
      pop        = 1'b0;
      if (state_q == StIdle) begin
         launch_d = 1'b0;
         if (count_q >= CW'(N_CH)) begin
            state_d  = StHdr0;
            launch_d = 1'b1;
         end
      end else if (launch_q) begin
         launch_d = 1'b0;
         data_d   = cur_byte;
         if (state_q == StSeq) csum_d = seq_q;
         if (state_q == StPay) begin
            csum_d = csum_q + pay_byte;
            pop    = (byte_idx_q == LAST_BYTE);
         end
      end else if (uart_tx_done) begin
         launch_d = 1'b1;
         case (state_q)
            StHdr0: state_d = StHdr1;
            StHdr1: state_d = StSeq;
            StSeq: begin
               state_d    = StPay;
               byte_idx_d = '0;
               samp_idx_d = '0;
            end
            StPay: begin
               if (byte_idx_q != LAST_BYTE) begin
                  byte_idx_d = byte_idx_q + BW'(1);
               end else begin
                  byte_idx_d = '0;
                  if (samp_idx_q == LAST_SAMP) begin
                     samp_idx_d = '0;
                     state_d    = StCsum;
                  end else begin
                     samp_idx_d = samp_idx_q + FIFO_AW'(1);
                  end
               end
            end
            StCsum: begin
               state_d  = StIdle;
               launch_d = 1'b0;
               seq_d    = seq_q + 8'd1;
            end
            default: begin
               state_d  = StIdle;
               launch_d = 1'b0;
            end
         endcase
      end
   end

   assign uart_tx_en   = launch_q && (state_q != StIdle);
   assign uart_tx_data = uart_tx_en ? cur_byte : data_q;
   assign busy         = (state_q != StIdle);
   assign overflow     = ovf_q;
   assign fifo_level   = count_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Directed bench for uart_frame_packer: frame content, sequence wrap, overflow,
// full-with-pop, handshake timing and asynchronous reset.
module tb_uart_frame_packer;

   localparam int FLEN = 12;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        sample_valid;
   logic [15:0] sample_data;
   logic        clear_ovf;
   logic        uart_tx_en;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_done;
   logic        busy;
   logic        overflow;
   logic [4:0]  fifo_level;

   int          errors = 0;
   int          checks = 0;
   logic        outstanding = 1'b0;
   logic [15:0] smp   [0:3];
   logic [15:0] smp8  [0:7];
   logic [7:0]  got   [0:FLEN-1];
   logic [7:0]  exp_b [0:FLEN-1];
   logic [7:0]  b;

   always #5 sys_clk = ~sys_clk;

   uart_frame_packer #(
      .SAMPLE_W (16),
      .N_CH     (4),
      .FIFO_AW  (4),
      .HDR0     (8'hA5),
      .HDR1     (8'h5A)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .clear_ovf    (clear_ovf),
      .uart_tx_en   (uart_tx_en),
      .uart_tx_data (uart_tx_data),
      .uart_tx_done (uart_tx_done),
      .busy         (busy),
      .overflow     (overflow),
      .fifo_level   (fifo_level)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic done_pulse();
      uart_tx_done = 1'b1;
      tick();
      uart_tx_done = 1'b0;
   endtask

   // Transmitter model: take the launched byte, answer done 'delay' cycles after en.
   task automatic recv_byte(input int delay, output logic [7:0] rb);
      int n = 0;
      while (uart_tx_en !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk("en_seen", uart_tx_en, 1'b1);
      rb = uart_tx_data;
      tick();
      chk("en_single_cycle", uart_tx_en, 1'b0);
      chk("data_hold", uart_tx_data, rb);
      repeat (delay - 1) tick();
      done_pulse();
   endtask

   task automatic recv_frame(input int delay, input int first);
      if (first > 0) done_pulse();
      for (int i = first; i < FLEN; i++) begin
         if (i > 0) chk("en_at_done_plus1", uart_tx_en, 1'b1);
         recv_byte(delay, got[i]);
      end
   endtask

   task automatic build_exp(input logic [7:0] seq);
      logic [7:0] sum;
      exp_b[0] = 8'hA5;
      exp_b[1] = 8'h5A;
      exp_b[2] = seq;
      sum = seq;
      for (int c = 0; c < 4; c++) begin
         exp_b[3+2*c] = smp[c][15:8];
         exp_b[4+2*c] = smp[c][7:0];
         sum = sum + smp[c][15:8] + smp[c][7:0];
      end
      exp_b[11] = sum;
   endtask

   task automatic cmp_frame(input string name, input int first);
      for (int i = first; i < FLEN; i++) chk($sformatf("%s_b%0d", name, i), got[i], exp_b[i]);
   endtask

   // Protocol monitor: no second launch before done, and no launch while idle.
   initial begin
      forever begin
         @(negedge sys_clk);
         if (sys_rst) begin
            outstanding = 1'b0;
         end else if (uart_tx_en) begin
            chk("en_repeat", outstanding, 1'b0);
            chk("en_while_idle", busy, 1'b1);
            outstanding = 1'b1;
         end else if (uart_tx_done) begin
            outstanding = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sys_rst      = 1'b1;
      sample_valid = 1'b0;
      sample_data  = 16'h0000;
      clear_ovf    = 1'b0;
      uart_tx_done = 1'b0;
      #1;
      chk("rst_en", uart_tx_en, 1'b0);
      chk("rst_data", uart_tx_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_level", fifo_level, 5'd0);
      repeat (2) tick();
      sys_rst = 1'b0;
      tick();

      // Spurious done while idle
      done_pulse();
      tick();
      chk("spur_busy", busy, 1'b0);
      chk("spur_en", uart_tx_en, 1'b0);
      chk("spur_level", fifo_level, 5'd0);

      // Basic frame, done 20 cycles after each en
      smp[0] = 16'h1234; smp[1] = 16'hABCD; smp[2] = 16'h00FF; smp[3] = 16'h8001;
      push(smp[0]);
      chk("level_after_push", fifo_level, 5'd1);
      for (int c = 1; c < 4; c++) push(smp[c]);
      chk("level_4", fifo_level, 5'd4);
      chk("latency_1", uart_tx_en, 1'b0);
      tick();
      chk("latency_2", uart_tx_en, 1'b1);
      chk("busy_in_frame", busy, 1'b1);
      recv_frame(20, 0);
      build_exp(8'h00);
      cmp_frame("basic", 0);
      chk("basic_busy_fall", busy, 1'b0);
      chk("basic_level", fifo_level, 5'd0);

      // Fast transmitter: done one cycle after en
      for (int c = 0; c < 4; c++) smp[c] = 16'h0102 + 16'(c) * 16'h0202;
      for (int c = 0; c < 4; c++) push(smp[c]);
      recv_frame(1, 0);
      build_exp(8'h01);
      cmp_frame("fast", 0);

      // Back-to-back frames; the first HDR0 launches while pushes are still going in
      smp8[0] = 16'hFFFF; smp8[1] = 16'h0000; smp8[2] = 16'h7F80; smp8[3] = 16'h0001;
      smp8[4] = 16'h1111; smp8[5] = 16'h2222; smp8[6] = 16'h3333; smp8[7] = 16'h4444;
      for (int c = 0; c < 8; c++) push(smp8[c]);
      chk("b2b_level", fifo_level, 5'd8);
      for (int c = 0; c < 4; c++) smp[c] = smp8[c];
      recv_frame(2, 1);
      build_exp(8'h02);
      cmp_frame("b2b_a", 1);
      chk("b2b_idle_en", uart_tx_en, 1'b0);
      chk("b2b_idle_busy", busy, 1'b0);
      tick();
      chk("b2b_launch", uart_tx_en, 1'b1);
      for (int c = 0; c < 4; c++) smp[c] = smp8[4+c];
      recv_frame(2, 0);
      build_exp(8'h03);
      cmp_frame("b2b_b", 0);

      // Overflow with no done returned: frame parks in HDR0 wait
      for (int i = 0; i < 16; i++) push(16'hC3A0 + 16'(i));
      chk("full_level", fifo_level, 5'd16);
      chk("full_no_ovf", overflow, 1'b0);
      push(16'hC3B0);
      chk("drop_level", fifo_level, 5'd16);
      chk("drop_ovf", overflow, 1'b1);
      sample_valid = 1'b1;
      sample_data  = 16'hC3B1;
      clear_ovf    = 1'b1;
      tick();
      sample_valid = 1'b0;
      clear_ovf    = 1'b0;
      chk("set_wins_ovf", overflow, 1'b1);
      chk("set_wins_level", fifo_level, 5'd16);
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      chk("clear_ovf", overflow, 1'b0);

      // Full FIFO, push coincident with the PAY last-byte launch
      done_pulse();
      recv_byte(1, b);
      chk("ovf_hdr1", b, 8'h5A);
      recv_byte(1, b);
      chk("ovf_seq", b, 8'h04);
      recv_byte(1, b);
      chk("ovf_pay0", b, 8'hC3);
      chk("pay1_en", uart_tx_en, 1'b1);
      chk("pay1_data", uart_tx_data, 8'hA0);
      sample_valid = 1'b1;
      sample_data  = 16'hBEEF;
      tick();
      sample_valid = 1'b0;
      chk("full_pop_level", fifo_level, 5'd16);
      chk("full_pop_ovf", overflow, 1'b0);
      push(16'hDEAD);
      chk("wait_drop_ovf", overflow, 1'b1);

      // Asynchronous reset mid-PAY
      #2;
      sys_rst = 1'b1;
      #1;
      chk("arst_en", uart_tx_en, 1'b0);
      chk("arst_data", uart_tx_data, 8'h00);
      chk("arst_busy", busy, 1'b0);
      chk("arst_ovf", overflow, 1'b0);
      chk("arst_level", fifo_level, 5'd0);
      repeat (2) tick();
      sys_rst = 1'b0;
      tick();

      // 257 frames from a fresh reset: SEQ 00..FF then 00
      for (int f = 0; f < 257; f++) begin
         for (int c = 0; c < 4; c++) smp[c] = 16'(f * 97 + c * 4099 + 16'h3C5A);
         for (int c = 0; c < 4; c++) push(smp[c]);
         recv_frame(1, 0);
         build_exp(8'(f));
         cmp_frame($sformatf("wrap%0d", f), 0);
      end
      tick();
      chk("end_busy", busy, 1'b0);
      chk("end_level", fifo_level, 5'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
